clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable rate controller for the board's 50 MHz system clock. It turns a selectable divisor into a one-cycle clock-enable tick and an optional derived square wave. The divisor comes from a four-entry preset table, stepped by debounced up/down button pulses, or from a direct load. Divisor changes are deferred to the period boundary so downstream logic (display refresh, LED blink, counters) never sees a truncated period. The block sits between the button front-end and every consumer of slow timing enables.

## Interface
Parameters:
- CNT_W, 26, width of the period counter and divisor; must hold the largest preset (50_000_000).
- DIV_MIN, 2, smallest legal divisor; smaller requests are clamped up to it.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- i_up  in  1  single-cycle pulse; select the next slower-to-faster preset (index +1).
- i_down  in  1  single-cycle pulse; select preset index −1.
- i_load  in  1  single-cycle pulse; request custom divisor i_div.
- i_div  in  CNT_W  custom divisor, sampled only when i_load=1.
- o_tick  out  1  one-cycle enable, once per period.
- o_clk  out  1  derived square wave (see Configuration).
- o_sel  out  2  current preset index.
- o_custom  out  1  active divisor came from i_load.
- o_busy  out  1  an update is pending, waiting for the period boundary.

## Operation
- Preset table by index: 0 = 50_000_000 (1 Hz), 1 = 5_000_000 (10 Hz), 2 = 500_000 (100 Hz), 3 = 50_000 (1 kHz).
- Request decode, per cycle:
  - i_load has priority over i_up/i_down.
  - i_up and i_down together are ignored.
  - i_up at index 3 and i_down at index 0 saturate: no request is made and o_busy stays 0.
  - Up/down step from the pending index if a request is pending, otherwise from o_sel.
- Load requests use i_div. Values below DIV_MIN are clamped to DIV_MIN.
- Pending register: a new request overwrites any older pending request (last request wins).
- State machine:
  - RUN: no pending request.
  - PEND: request latched, o_busy=1. Stays in PEND until the wrap edge.
  - On the wrap edge: active divisor, o_sel and o_custom take the pending values, then return to RUN.
- Counter: counts 0..div−1. The wrap edge is the edge where the count goes from div−1 to 0.
- A request sampled on the wrap edge applies directly to the period starting at that edge. o_busy does not assert.
- A preset step clears o_custom. A load sets o_custom and leaves o_sel unchanged.

## Timing
- Reset values: count=0, divisor=preset 0, o_sel=0, o_custom=0, o_busy=0, o_tick=0, o_clk=0, state RUN.
- o_tick is registered. It is high for exactly one cycle in every div cycles: the cycle following each wrap edge.
- The first o_tick is high in cycle div after reset release. Cycle 1 is the first cycle with rst low.
- o_busy rises the cycle after a non-wrap request. It falls in the same cycle the new o_sel/o_custom appear, i.e. the cycle after the wrap edge.
- The first period after the update has exactly the new length.
- Reset asserted mid-period or while a request is pending: the pending request is discarded and all reset values apply on the next edge.

## Configuration
- CLK_DIV_CTRL_SQUARE_EN defined:
  - o_clk is registered. It goes high on each wrap edge and low on the edge where count reaches (div>>1).
  - High time is div>>1 cycles; low time is div−(div>>1) cycles (odd divisors give the extra cycle to the low phase).
- Not defined: o_clk is tied to 0 and the square-wave register is not built.

## Structure
- Package clk_div_pkg holds:
  - preset constants DIV_P0..DIV_P3,
  - SEL_W=2 and the preset index type,
  - the state encoding (RUN, PEND),
  - a function mapping index to divisor.
- One natural sub-module, clk_div_core: counter, wrap detect, o_tick and the optional o_clk.
- clk_div_ctrl itself holds request decode, saturation, the pending register and the FSM.
- Simulation benches override the presets via the package to get short periods.

## Test plan
- Reset release, preset 0 with bench preset values 8/6/4/2 → o_tick high in cycles 8, 16, 24. Square wave (when enabled): 4 cycles high, 4 cycles low.
- i_load with i_div=5 at count=2 → o_busy=1 until the wrap. Next period is 5 cycles. o_custom=1, o_sel still 0. With square enabled: 2 high, 3 low.
- i_load with i_div=1 → divisor clamped to 2; o_tick toggles every other cycle.
- i_up three times in one period → single update to index 3 at the wrap. A fourth i_up is ignored and o_busy stays 0.
- i_up and i_down in the same cycle → no change, o_busy=0. i_down at index 0 → no change.
- i_load on the exact wrap edge → new period immediately has the new length and o_busy never asserts. rst during PEND → o_sel=0 and the period restarts at preset 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the programmable clock divider.
package clk_div_pkg;
  localparam int unsigned DIV_P0 = 50_000_000;
  localparam int unsigned DIV_P1 = 5_000_000;
  localparam int unsigned DIV_P2 = 500_000;
  localparam int unsigned DIV_P3 = 50_000;

  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  localparam sel_t SEL_MAX = '1;

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  // Table values are passed in so simulation can shorten the periods.
  function automatic int unsigned preset_div(sel_t s, int unsigned p0, int unsigned p1,
                                             int unsigned p2, int unsigned p3);
    case (s)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction
endpackage

// File: rtl/clk_div_core.sv
// Period counter, wrap detect, registered tick and optional square wave.
// Square wave built only when CLK_DIV_CTRL_SQUARE_EN is defined.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             o_tick,
  output logic             o_clk
);
  logic [CNT_W-1:0] cnt;

  // >= keeps the counter bounded even if div were lowered mid-period.
  assign wrap = (cnt >= div - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      o_tick <= wrap;
    end
  end

`ifdef CLK_DIV_CTRL_SQUARE_EN
  logic [CNT_W-1:0] half;
  logic             sq;

  assign half  = div >> 1;
  assign o_clk = sq;

  always_ff @(posedge clk) begin
    if (rst)                         sq <= 1'b0;
    else if (wrap)                   sq <= 1'b1;
    else if ((cnt + 1'b1) == half)   sq <= 1'b0;
  end
`else
  assign o_clk = 1'b0;
`endif
endmodule

// File: rtl/clk_div_ctrl.sv
// Divisor selection (presets, up/down, direct load) with updates deferred to
// the period boundary. Optional square wave: CLK_DIV_CTRL_SQUARE_EN.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W    = 26,
  parameter int          DIV_MIN  = 2,
  parameter int unsigned DIV_P0_V = DIV_P0,
  parameter int unsigned DIV_P1_V = DIV_P1,
  parameter int unsigned DIV_P2_V = DIV_P2,
  parameter int unsigned DIV_P3_V = DIV_P3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_clk,
  output logic [1:0]       o_sel,
  output logic             o_custom,
  output logic             o_busy
);
  function automatic logic [CNT_W-1:0] div_of(sel_t s);
    return CNT_W'(preset_div(s, DIV_P0_V, DIV_P1_V, DIV_P2_V, DIV_P3_V));
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] div_q, pend_div, req_div, load_div;
  sel_t             sel_q, pend_sel, req_sel, base_sel;
  logic             custom_q, pend_custom, req_custom, req_vld, wrap;

  // Steps chain off a pending index so several presses in one period add up.
  assign base_sel = (state == PEND) ? pend_sel : sel_q;
  assign load_div = (i_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : i_div;

  always_comb begin
    req_vld    = 1'b0;
    req_sel    = sel_q;
    req_div    = div_q;
    req_custom = 1'b0;
    if (i_load) begin
      req_vld    = 1'b1;
      req_div    = load_div;
      req_custom = 1'b1;
    end else if (i_up && !i_down && base_sel != SEL_MAX) begin
      req_vld = 1'b1;
      req_sel = sel_t'(base_sel + 1'b1);
      req_div = div_of(req_sel);
    end else if (i_down && !i_up && base_sel != '0) begin
      req_vld = 1'b1;
      req_sel = sel_t'(base_sel - 1'b1);
      req_div = div_of(req_sel);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:  if (req_vld && !wrap) state_n = PEND;
      PEND: if (wrap)             state_n = RUN;
      default:                    state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      div_q       <= div_of('0);
      sel_q       <= '0;
      custom_q    <= 1'b0;
      pend_div    <= '0;
      pend_sel    <= '0;
      pend_custom <= 1'b0;
    end else begin
      state <= state_n;
      if (wrap) begin
        // A request landing on the wrap edge beats the older pending one.
        if (req_vld) begin
          div_q    <= req_div;
          sel_q    <= req_sel;
          custom_q <= req_custom;
        end else if (state == PEND) begin
          div_q    <= pend_div;
          sel_q    <= pend_sel;
          custom_q <= pend_custom;
        end
      end else if (req_vld) begin
        pend_div    <= req_div;
        pend_sel    <= req_sel;
        pend_custom <= req_custom;
      end
    end
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .div    (div_q),
    .wrap   (wrap),
    .o_tick (o_tick),
    .o_clk  (o_clk)
  );

  assign o_sel    = sel_q;
  assign o_custom = custom_q;
  assign o_busy   = (state == PEND);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with short presets 8/6/4/2; tick cycles
// are queued ahead and matched by a per-cycle monitor.
module tb_clk_div_ctrl;
  localparam int CNT_W = 26;
`ifdef CLK_DIV_CTRL_SQUARE_EN
  localparam logic SQ = 1'b1;
`else
  localparam logic SQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, i_up, i_down, i_load;
  logic [CNT_W-1:0] i_div;
  logic             o_tick, o_clk, o_custom, o_busy;
  logic [1:0]       o_sel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick_q[$];

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .CNT_W(CNT_W), .DIV_MIN(2),
    .DIV_P0_V(8), .DIV_P1_V(6), .DIV_P2_V(4), .DIV_P3_V(2)
  ) dut (
    .clk(clk), .rst(rst), .i_up(i_up), .i_down(i_down), .i_load(i_load),
    .i_div(i_div), .o_tick(o_tick), .o_clk(o_clk), .o_sel(o_sel),
    .o_custom(o_custom), .o_busy(o_busy)
  );

  // Cycle n = the period after the n-th rising edge that sampled rst low.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    checks++;
    if (tick_q.size() != 0 && tick_q[0] == cyc) begin
      assert (o_tick === 1'b1) else begin
        errors++;
        $error("FAIL tick_expected cyc=%0d obs=%b exp=1", cyc, o_tick);
      end
      void'(tick_q.pop_front());
    end else begin
      assert (o_tick === 1'b0) else begin
        errors++;
        $error("FAIL tick_unexpected cyc=%0d obs=%b exp=0", cyc, o_tick);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic at(input int n);
    int b = 0;
    while (cyc != n && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (cyc != n) begin
      errors++;
      $error("FAIL wait_cycle obs=%0d exp=%0d", cyc, n);
    end
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input int dv);
    i_up = u; i_down = d; i_load = l; i_div = CNT_W'(dv);
    @(negedge clk);
    i_up = 1'b0; i_down = 1'b0; i_load = 1'b0; i_div = '0;
  endtask

  initial begin
    rst = 1'b1; i_up = 1'b0; i_down = 1'b0; i_load = 1'b0; i_div = '0;
    repeat (3) @(negedge clk);
    chk("rst_tick", o_tick, 0);
    chk("rst_clk", o_clk, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_custom", o_custom, 0);
    chk("rst_busy", o_busy, 0);
    foreach (tick_q[i]) tick_q.delete(i);
    tick_q = '{8, 16, 24, 32, 37, 42, 47, 49, 51, 55, 57, 59};
    rst = 1'b0;

    // Preset 0 (8 cycles): square high 8..11, low 12..15
    at(8);  chk("sq8_hi", o_clk, SQ);
    at(11); chk("sq8_hi_end", o_clk, SQ);
    at(12); chk("sq8_lo", o_clk, 0);
    at(15); chk("sq8_lo_end", o_clk, 0);

    // Load 5 mid-period (sampled while count=2)
    at(26); pulse(0, 0, 1, 5);
    chk("load_busy", o_busy, 1);
    chk("load_custom_pre", o_custom, 0);
    at(31); chk("load_busy_hold", o_busy, 1);
    at(32); chk("load_busy_fall", o_busy, 0);
    chk("load_custom", o_custom, 1);
    chk("load_sel", o_sel, 0);
    chk("sq5_hi", o_clk, SQ);
    at(33); chk("sq5_hi_end", o_clk, SQ);
    at(34); chk("sq5_lo", o_clk, 0);
    at(36); chk("sq5_lo_end", o_clk, 0);
    at(37); chk("sq5_rehi", o_clk, SQ);

    // Three ups in one period collapse into one update to index 3
    at(42); pulse(1, 0, 0, 0);
    chk("up_busy", o_busy, 1);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("up_busy3", o_busy, 1);
    chk("up_sel_pre", o_sel, 0);
    at(47); chk("up_sel", o_sel, 3);
    chk("up_custom", o_custom, 0);
    chk("up_busy_fall", o_busy, 0);
    pulse(1, 0, 0, 0);
    chk("up_sat_busy", o_busy, 0);
    chk("up_sat_sel", o_sel, 3);

    // Up+down together ignored; down on the wrap edge applies at once
    at(49); pulse(1, 1, 0, 0);
    chk("updn_busy", o_busy, 0);
    chk("updn_sel", o_sel, 3);
    pulse(0, 1, 0, 0);
    chk("dn_wrap_sel", o_sel, 2);
    chk("dn_wrap_busy", o_busy, 0);

    // Load 1 clamps to 2
    pulse(0, 0, 1, 1);
    chk("clamp_busy", o_busy, 1);
    chk("clamp_sel_pre", o_sel, 2);
    at(55); chk("clamp_custom", o_custom, 1);
    chk("clamp_sel", o_sel, 2);
    chk("clamp_busy_fall", o_busy, 0);

    // Load on the exact wrap edge: no busy, new length immediately
    at(58); pulse(0, 0, 1, 6);
    chk("wrapload_busy", o_busy, 0);
    chk("wrapload_custom", o_custom, 1);

    // Reset while pending discards the request
    at(60); pulse(1, 0, 0, 0);
    chk("pend_busy", o_busy, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_sel", o_sel, 0);
    chk("rst2_busy", o_busy, 0);
    chk("rst2_custom", o_custom, 0);
    chk("rst2_ticks_left", tick_q.size(), 0);
    tick_q.push_back(8);
    tick_q.push_back(16);
    rst = 1'b0;
    at(1); chk("rst2_sel_c1", o_sel, 0);

    // Down at index 0 saturates
    at(2); pulse(0, 1, 0, 0);
    chk("dn_sat_busy", o_busy, 0);
    chk("dn_sat_sel", o_sel, 0);
    at(17);
    chk("ticks_drained", tick_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
